uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
Parametrised next-generation UART transmitter for the console mux. It serialises one word per frame: start bit, 5-9 data bits LSB first, optional odd/even parity, then 1-2 stop bits.
- A one-entry holding register with a valid/ready handshake lets the upstream mux queue the next character during a frame, so frames go back-to-back with no idle gap.
- The line idles high, and stop bits are driven high.

Parameters:
DATA_BITS, 8, data bits per frame, legal 5..9
PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits per frame, legal 1..2
CLK_PER_BIT, 8, clk cycles per bit period, legal >= 2

Ports:
clk  in  1  single clock; all logic on posedge
rst  in  1  synchronous, active-high reset
data  in  DATA_BITS  word to send, sampled on accept
data_valid  in  1  upstream has a word
data_ready  out  1  holding register empty; transfer when data_valid && data_ready
busy  out  1  a frame is on the line (START..STOP)
done  out  1  one-cycle pulse in the last cycle of a frame's final stop bit
serial  out  1  TX line, idle high

Behaviour:
- Reset (rst high at a clock edge) clears the shifter, holding register, counters and state. From the next edge:
  - serial = 1, busy = 0, done = 0, data_ready = 0 while rst is held.
  - data_ready = 1 in the first cycle after rst deasserts.
- Reset mid-frame aborts the frame: serial returns to 1 at the next edge, with no done pulse and the queued word discarded.
- Holding register:
  - An accept loads data into the holding register; data_ready drops the next cycle.
  - The register empties when its word moves into the shifter; data_ready rises the next cycle.
  - data_valid without data_ready is ignored, and the word must stay stable until accepted.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: serial = 1. When the holding register is full, move its word to the shifter and go to START.
  - Latency: accept in cycle T with FSM idle and register empty gives serial = 0 from edge T+2 (one cycle to fill, one to launch).
  - START: drive 0 for exactly CLK_PER_BIT cycles, then go to DATA.
  - DATA: drive shifter[0] for CLK_PER_BIT cycles per bit, shift right, DATA_BITS bits. Then go to PARITY if PARITY_MODE != 0, else to STOP.
  - PARITY: drive the parity bit for CLK_PER_BIT cycles. Even: XOR of the data bits. Odd: the inverse of that XOR. Parity is computed from the accepted word, not the partially shifted register.
  - STOP: drive 1 for STOP_BITS × CLK_PER_BIT cycles.
  - End of STOP: pulse done in the final STOP cycle. If the holding register is full, load it and enter START on the next edge (no idle cycle); otherwise go to IDLE.
- Every bit is exactly CLK_PER_BIT cycles. The bit-cycle counter resets to 0 on every bit boundary, so there is no drift.
- Frame length = (1 + DATA_BITS + (PARITY_MODE != 0) + STOP_BITS) × CLK_PER_BIT cycles.
- busy is high from the first START cycle through the last STOP cycle.
- Accept in the same cycle the holding register drains: not possible, since data_ready is registered low while the register is full.
- Widths:
  - Bit counter is $clog2(DATA_BITS+1) wide.
  - Cycle counter is $clog2(CLK_PER_BIT) wide and must not overflow at CLK_PER_BIT = 2^n.
- Illegal parameters fail elaboration via generate-time checks; no runtime $finish.

Decomposition:
- Shared package uart_pkg:
  - Parity mode constants (PARITY_NONE/ODD/EVEN).
  - FSM state encodings.
  - Parameter-legality functions, reused by the future uart_rx_frame.
- Sub-module uart_bit_timer: counts CLK_PER_BIT cycles and emits a bit_end pulse, with a restart input. It is shared with the RX side.

Test Plan:
1. CLK_PER_BIT = 4, 8N1, send 0x55 → serial 0,1,0,1,0,1,0,1,0,1, each 4 cycles; done pulses at cycle 40 of the frame; busy high 40 cycles.
2. 8E1, send 0x03 → parity bit 0. 8O1, send 0x03 → parity bit 1. Frame is 44 cycles.
3. DATA_BITS = 7, odd parity, 2 stop bits, send 0x41 → 7 data bits 1,0,0,0,0,0,1, parity 1, 8 high stop cycles, frame 44 cycles.
4. Back-to-back: offer 0xA5 while data_ready is high mid-frame of 0x3C → data_ready drops 1 cycle after accept. The 0xA5 start bit follows the 0x3C final stop cycle directly, with no idle cycle; two done pulses 40 cycles apart.
5. Reset mid-DATA of 0xFF with a word queued → serial = 1 next edge, no done pulse, data_ready = 1 one cycle after rst drops, queued word never appears.
6. DATA_BITS = 9, CLK_PER_BIT = 2, send 0x1FF with data_valid held continuously → consecutive frames of 22 cycles each; never an idle-high gap longer than the stop bit.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, frame FSM encoding, parameter legality.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  function automatic bit uart_legal_data_bits(input int n);
    return (n >= 5) && (n <= 9);
  endfunction

  function automatic bit uart_legal_parity(input int m);
    return (m >= PARITY_NONE) && (m <= PARITY_EVEN);
  endfunction

  function automatic bit uart_legal_stop_bits(input int n);
    return (n >= 1) && (n <= 2);
  endfunction

  function automatic bit uart_legal_clk_per_bit(input int n);
    return n >= 2;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts CLK_PER_BIT cycles, flags the last and next-to-last cycle of each bit.
module uart_bit_timer #(
  parameter int CLK_PER_BIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic restart_i,
  output logic bit_end_o,
  output logic pre_end_o
);

  localparam int CW = $clog2(CLK_PER_BIT);

  logic [CW-1:0] cnt_q, cnt_d;

  // The counter never holds more than CLK_PER_BIT-1, so CW bits suffice even at 2^n.
  assign bit_end_o = (cnt_q == CW'(CLK_PER_BIT - 1));
  assign pre_end_o = (cnt_q == CW'(CLK_PER_BIT - 2));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart_i || bit_end_o) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: one-entry holding register feeding a start/data/parity/stop serialiser.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int CLK_PER_BIT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 data_valid,
  output logic                 data_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 serial
);

  localparam int BW = $clog2(DATA_BITS + 1);

  if (!uart_legal_data_bits(DATA_BITS)) begin : g_bad_data_bits
    $error("uart_tx_frame: DATA_BITS must be 5..9");
  end
  if (!uart_legal_parity(PARITY_MODE)) begin : g_bad_parity
    $error("uart_tx_frame: PARITY_MODE must be 0..2");
  end
  if (!uart_legal_stop_bits(STOP_BITS)) begin : g_bad_stop_bits
    $error("uart_tx_frame: STOP_BITS must be 1..2");
  end
  if (!uart_legal_clk_per_bit(CLK_PER_BIT)) begin : g_bad_clk_per_bit
    $error("uart_tx_frame: CLK_PER_BIT must be >= 2");
  end

  uart_state_e          state_q;
  logic [DATA_BITS-1:0] hold_q, shift_q;
  logic                 hold_full_q, hold_full_d, ready_q;
  logic [BW-1:0]        bit_cnt_q;
  logic                 stop_idx_q, par_q;
  logic                 serial_q, busy_q, done_q;
  logic                 bit_end, pre_end, last_stop, accept, load;

  assign accept    = data_valid && ready_q;
  assign last_stop = (STOP_BITS == 1) || stop_idx_q;
  // Hand the queued word to the shifter from idle, or straight off the final stop cycle.
  assign load      = hold_full_q &&
                     ((state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_end && last_stop));

  uart_bit_timer #(.CLK_PER_BIT(CLK_PER_BIT)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .restart_i (state_q == ST_IDLE),
    .bit_end_o (bit_end),
    .pre_end_o (pre_end)
  );

  always_comb begin
    hold_full_d = hold_full_q;
    if (accept)    hold_full_d = 1'b1;
    else if (load) hold_full_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      if (accept) hold_q <= data;
      hold_full_q <= hold_full_d;
      ready_q     <= !hold_full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_idx_q <= 1'b0;
      par_q      <= 1'b0;
      serial_q   <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      // Registered, so raise it one cycle ahead of the final stop cycle.
      done_q <= (state_q == ST_STOP) && last_stop && pre_end;
      if (load) begin
        shift_q  <= hold_q;
        par_q    <= (^hold_q) ^ (PARITY_MODE == PARITY_ODD);
        state_q  <= ST_START;
        serial_q <= 1'b0;
        busy_q   <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: begin
            serial_q <= 1'b1;
            busy_q   <= 1'b0;
          end
          ST_START: if (bit_end) begin
            state_q   <= ST_DATA;
            serial_q  <= shift_q[0];
            shift_q   <= shift_q >> 1;
            bit_cnt_q <= BW'(1);
          end
          ST_DATA: if (bit_end) begin
            if (bit_cnt_q == BW'(DATA_BITS)) begin
              stop_idx_q <= 1'b0;
              if (PARITY_MODE != PARITY_NONE) begin
                state_q  <= ST_PARITY;
                serial_q <= par_q;
              end else begin
                state_q  <= ST_STOP;
                serial_q <= 1'b1;
              end
            end else begin
              serial_q  <= shift_q[0];
              shift_q   <= shift_q >> 1;
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
          ST_PARITY: if (bit_end) begin
            state_q    <= ST_STOP;
            serial_q   <= 1'b1;
            stop_idx_q <= 1'b0;
          end
          ST_STOP: if (bit_end) begin
            if (last_stop) begin
              state_q  <= ST_IDLE;
              serial_q <= 1'b1;
              busy_q   <= 1'b0;
            end else begin
              stop_idx_q <= 1'b1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign data_ready = ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign serial     = serial_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: four configurations against a per-cycle frame model, plus directed vectors.
module tb_uart_tx_frame;

  localparam int NI   = 4;
  localparam int NCYC = 9000;
  localparam int DBV [NI] = '{8, 8, 7, 9};
  localparam int PMV [NI] = '{0, 2, 1, 0};
  localparam int SBV [NI] = '{1, 1, 2, 1};
  localparam int CPV [NI] = '{4, 4, 4, 2};

  logic       clk = 1'b0;
  logic       rst_v [NI];
  logic       dv    [NI];
  logic [8:0] din   [NI];
  logic       ser   [NI];
  logic       bsy   [NI];
  logic       dn    [NI];
  logic       rdy   [NI];

  always #5 clk = ~clk;

  uart_tx_frame #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .CLK_PER_BIT(4)) u0 (
    .clk(clk), .rst(rst_v[0]), .data(din[0][7:0]), .data_valid(dv[0]),
    .data_ready(rdy[0]), .busy(bsy[0]), .done(dn[0]), .serial(ser[0]));
  uart_tx_frame #(.DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1), .CLK_PER_BIT(4)) u1 (
    .clk(clk), .rst(rst_v[1]), .data(din[1][7:0]), .data_valid(dv[1]),
    .data_ready(rdy[1]), .busy(bsy[1]), .done(dn[1]), .serial(ser[1]));
  uart_tx_frame #(.DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2), .CLK_PER_BIT(4)) u2 (
    .clk(clk), .rst(rst_v[2]), .data(din[2][6:0]), .data_valid(dv[2]),
    .data_ready(rdy[2]), .busy(bsy[2]), .done(dn[2]), .serial(ser[2]));
  uart_tx_frame #(.DATA_BITS(9), .PARITY_MODE(0), .STOP_BITS(1), .CLK_PER_BIT(2)) u3 (
    .clk(clk), .rst(rst_v[3]), .data(din[3]), .data_valid(dv[3]),
    .data_ready(rdy[3]), .busy(bsy[3]), .done(dn[3]), .serial(ser[3]));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model: expected line per cycle ----------------
  int  cyc = 0;
  bit  e_ser [NI][NCYC];
  bit  e_bsy [NI][NCYC];
  bit  e_dn  [NI][NCYC];
  bit  e_rdy [NI];
  int  next_free [NI];
  int  hold_end  [NI];
  bit  acc_seen  [NI];
  bit  chk_en = 1'b0;

  function automatic int frame_len(input int i);
    return (1 + DBV[i] + ((PMV[i] != 0) ? 1 : 0) + SBV[i]) * CPV[i];
  endfunction

  // Line level during bit period k of a frame carrying word w.
  function automatic bit frame_bit(input int i, input logic [8:0] w, input int k);
    bit p;
    if (k == 0) return 1'b0;
    if (k <= DBV[i]) return w[k-1];
    if (PMV[i] != 0 && k == DBV[i] + 1) begin
      p = 1'b0;
      for (int b = 0; b < DBV[i]; b++) p = p ^ w[b];
      return (PMV[i] == 2) ? p : !p;
    end
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      acc_seen[i] = 1'b0;
      if (rst_v[i]) begin
        for (int c = cyc + 1; c < NCYC && c < next_free[i]; c++) begin
          e_ser[i][c] = 1'b1;
          e_bsy[i][c] = 1'b0;
          e_dn[i][c]  = 1'b0;
        end
        next_free[i] = 0;
        hold_end[i]  = -1;
        e_rdy[i]     = 1'b0;
      end else begin
        if (dv[i] && e_rdy[i]) begin
          int s, len;
          s   = (cyc + 2 > next_free[i]) ? cyc + 2 : next_free[i];
          len = frame_len(i);
          for (int j = 0; j < len; j++) begin
            if (s + j < NCYC) begin
              e_ser[i][s+j] = frame_bit(i, din[i], j / CPV[i]);
              e_bsy[i][s+j] = 1'b1;
              e_dn[i][s+j]  = (j == len - 1);
            end
          end
          next_free[i] = s + len;
          hold_end[i]  = s - 1;
          acc_seen[i]  = 1'b1;
        end
        e_rdy[i] = (cyc + 1 > hold_end[i]);
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (chk_en && cyc < NCYC) begin
      for (int i = 0; i < NI; i++) begin
        checks++;
        if ({ser[i], bsy[i], dn[i], rdy[i]} !==
            {e_ser[i][cyc], e_bsy[i][cyc], e_dn[i][cyc], e_rdy[i]}) begin
          failures++;
          $display("FAIL model u%0d cyc=%0d ser/busy/done/ready got %b%b%b%b expected %b%b%b%b",
                   i, cyc, ser[i], bsy[i], dn[i], rdy[i],
                   e_ser[i][cyc], e_bsy[i][cyc], e_dn[i][cyc], e_rdy[i]);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_idle(input int i);
    int k;
    for (k = 0; k < 400; k++) begin
      @(negedge clk);
      if (next_free[i] <= cyc && e_rdy[i] && !dv[i]) break;
    end
    if (k == 400) chk("wait_idle_timeout", 0, 1);
  endtask

  // Offer w and return at the negedge of the cycle after the accept edge.
  task automatic offer(input int i, input logic [8:0] w);
    int k;
    @(negedge clk);
    din[i] = w;
    dv[i]  = 1'b1;
    for (k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      if (acc_seen[i]) break;
    end
    if (k == 100) chk("accept_timeout", 0, 1);
    @(negedge clk);
    dv[i] = 1'b0;
  endtask

  typedef struct {
    int         inst;
    logic [8:0] word;
    int         nper;
    logic [15:0] line;
  } vec_t;

  vec_t tbl [8];

  task automatic run_vec(input vec_t v);
    int i, cpb, len, busy_n, done_at;
    logic [15:0] line;
    i = v.inst; cpb = CPV[i]; len = v.nper * cpb;
    line = '0; busy_n = 0; done_at = -1;
    wait_idle(i);
    offer(i, v.word);
    for (int j = 0; j < len; j++) begin
      @(negedge clk);
      if (j % cpb == cpb / 2) line[j / cpb] = ser[i];
      if (bsy[i]) busy_n++;
      if (dn[i]) done_at = j + 1;
    end
    chk($sformatf("vec_line u%0d w=%0h", i, v.word), int'(line), int'(v.line));
    chk($sformatf("vec_busy u%0d w=%0h", i, v.word), busy_n, len);
    chk($sformatf("vec_done u%0d w=%0h", i, v.word), done_at, len);
    @(negedge clk);
    chk($sformatf("vec_idle u%0d", i), int'({ser[i], bsy[i]}), 2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    int nd, d0, d1, lows, run, maxrun, badgap, last_d;
    for (int i = 0; i < NI; i++) begin
      for (int c = 0; c < NCYC; c++) e_ser[i][c] = 1'b1;
      next_free[i] = 0; hold_end[i] = -1; e_rdy[i] = 1'b0;
      rst_v[i] = 1'b1; dv[i] = 1'b0; din[i] = '0;
    end
    tbl[0] = '{0, 9'h055, 10, 16'h02AA};
    tbl[1] = '{0, 9'h000, 10, 16'h0200};
    tbl[2] = '{1, 9'h003, 11, 16'h0406};
    tbl[3] = '{1, 9'h0FF, 11, 16'h05FE};
    tbl[4] = '{2, 9'h041, 11, 16'h0782};
    tbl[5] = '{2, 9'h003, 11, 16'h0706};
    tbl[6] = '{3, 9'h1FF, 11, 16'h07FE};
    tbl[7] = '{3, 9'h100, 11, 16'h0600};

    @(posedge clk);
    chk_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NI; i++)
      chk($sformatf("reset_state u%0d", i), int'({ser[i], bsy[i], dn[i], rdy[i]}), 8);
    for (int i = 0; i < NI; i++) rst_v[i] = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) chk($sformatf("ready_after_reset u%0d", i), rdy[i], 1);

    for (int t = 0; t < 8; t++) run_vec(tbl[t]);

    // Back-to-back: second word queued mid-frame, no idle cycle between frames.
    wait_idle(0);
    offer(0, 9'h03C);
    nd = 0; d0 = -1; d1 = -1;
    for (int j = 0; j < 100; j++) begin
      @(negedge clk);
      if (j == 10) begin din[0] = 9'h0A5; dv[0] = 1'b1; end
      if (j == 11) begin chk("b2b_ready_drop", rdy[0], 0); dv[0] = 1'b0; end
      if (j == 40) chk("b2b_no_gap_start", ser[0], 0);
      if (dn[0]) begin
        if (nd == 0) d0 = j; else d1 = j;
        nd++;
      end
    end
    chk("b2b_done_count", nd, 2);
    chk("b2b_first_done", d0, 39);
    chk("b2b_done_gap", d1 - d0, 40);

    // Reset mid-DATA with a word queued.
    wait_idle(1);
    offer(1, 9'h0FF);
    din[1] = 9'h012;
    dv[1]  = 1'b1;
    begin
      int k;
      for (k = 0; k < 20; k++) begin
        @(posedge clk);
        #1;
        if (acc_seen[1]) break;
      end
      if (k == 20) chk("rst_queue_timeout", 0, 1);
    end
    @(negedge clk);
    dv[1] = 1'b0;
    repeat (13) @(negedge clk);
    rst_v[1] = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_line", int'({ser[1], bsy[1], dn[1], rdy[1]}), 8);
    @(negedge clk);
    @(negedge clk);
    rst_v[1] = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_ready_after", rdy[1], 1);
    lows = 0; nd = 0;
    for (int j = 0; j < 80; j++) begin
      @(negedge clk);
      if (!ser[1]) lows++;
      if (dn[1]) nd++;
    end
    chk("rst_queued_dropped", lows, 0);
    chk("rst_no_done", nd, 0);

    // Continuous valid on the 9N1 / 2-cycle instance.
    wait_idle(3);
    @(negedge clk);
    din[3] = 9'h1FF;
    dv[3]  = 1'b1;
    nd = 0; badgap = 0; last_d = -1; run = 0; maxrun = 0;
    for (int j = 0; j < 150; j++) begin
      @(negedge clk);
      if (dn[3]) begin
        if (last_d >= 0 && j - last_d != 22) badgap++;
        last_d = j;
        nd++;
      end
      if (j > 4) begin
        if (ser[3]) run++; else run = 0;
        if (run > maxrun) maxrun = run;
      end
    end
    dv[3] = 1'b0;
    chk("cont_done_count", int'(nd >= 6), 1);
    chk("cont_bad_gaps", badgap, 0);
    chk("cont_max_high_run", int'(maxrun <= 20), 1);

    // Randomised traffic with occasional resets, checked by the model every cycle.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (!(dv[i] && !acc_seen[i])) begin
          dv[i]  = ($urandom_range(0, 2) == 0);
          din[i] = 9'($urandom_range(0, 511));
        end
        rst_v[i] = ($urandom_range(0, 399) == 0);
      end
    end
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin dv[i] = 1'b0; rst_v[i] = 1'b0; end
    repeat (200) @(negedge clk);
    for (int i = 0; i < NI; i++) chk($sformatf("final_idle u%0d", i), int'({ser[i], bsy[i]}), 2);
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
